// File: rtl/iob_pulse_train_if.sv
// ---------------------------------------------------------------------------
// iob_pulse_train_if
//
// Bundles everything the pulse-train generator exchanges with its controller.
// The controller side (register bank, local sequencer or testbench) uses the
// master modport. The generator uses the slave modport.
//
// Parameters:
//   CHANNELS - number of independent channels
//   WIDTH    - width of every timing field
//
// Signals (master drives -> slave):
//   trig         [CHANNELS]        per-channel start
//   stop         [CHANNELS]        per-channel abort
//   cfg_start    [CHANNELS*WIDTH]  delay before first pulse, channel c at [c*WIDTH +: WIDTH]
//   cfg_duration [CHANNELS*WIDTH]  pulse high time
//   cfg_period   [CHANNELS*WIDTH]  rising-to-rising distance
//   cfg_repeat   [CHANNELS*WIDTH]  number of pulses, 0 = continuous
//   irq_clr      [CHANNELS]        per-channel irq flag clear (IOB_PULSE_TRAIN_IRQ_EN only)
// Signals (slave drives -> master):
//   pulse_out    [CHANNELS]        registered pulse outputs
//   busy         [CHANNELS]        channel running
//   done         [CHANNELS]        one-cycle completion strobe
//   irq                            OR of sticky done flags (IOB_PULSE_TRAIN_IRQ_EN only)
//
// Optional feature macro: IOB_PULSE_TRAIN_IRQ_EN
// ---------------------------------------------------------------------------
interface iob_pulse_train_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
);

    logic [CHANNELS-1:0]       trig;
    logic [CHANNELS-1:0]       stop;
    logic [CHANNELS*WIDTH-1:0] cfg_start;
    logic [CHANNELS*WIDTH-1:0] cfg_duration;
    logic [CHANNELS*WIDTH-1:0] cfg_period;
    logic [CHANNELS*WIDTH-1:0] cfg_repeat;
    logic [CHANNELS-1:0]       pulse_out;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;
`ifdef IOB_PULSE_TRAIN_IRQ_EN
    logic [CHANNELS-1:0]       irq_clr;
    logic                      irq;
`endif

    // Controller view: drives triggers and configuration, observes status.
    modport master (
        output trig, stop, cfg_start, cfg_duration, cfg_period, cfg_repeat,
`ifdef IOB_PULSE_TRAIN_IRQ_EN
        output irq_clr,
        input  irq,
`endif
        input  pulse_out, busy, done
    );

    // Generator view: consumes triggers and configuration, drives status.
    modport slave (
        input  trig, stop, cfg_start, cfg_duration, cfg_period, cfg_repeat,
`ifdef IOB_PULSE_TRAIN_IRQ_EN
        input  irq_clr,
        output irq,
`endif
        output pulse_out, busy, done
    );

endinterface

// File: rtl/iob_pulse_train.sv
// ---------------------------------------------------------------------------
// iob_pulse_train
//
// Multi-channel programmable pulse-train generator. After a trigger, each
// channel waits cfg_start cycles and then emits cfg_repeat pulses (0 means
// run until stopped). Each pulse is cfg_duration cycles high. Pulses repeat
// every effective period. A one-cycle done strobe marks the end of a finite
// train. Every channel is independent and has its own FSM, counters and
// shadow copy of its configuration.
//
// Parameters:
//   CHANNELS - number of independent channels (>= 1)
//   WIDTH    - width of timing fields and internal counters (2..32)
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - iob_pulse_train_if.slave: trig/stop/cfg_* in, pulse_out/busy/done out
//            (plus irq_clr in / irq out when IOB_PULSE_TRAIN_IRQ_EN is defined)
//
// Optional feature macro: IOB_PULSE_TRAIN_IRQ_EN
//   Adds one sticky flag per channel. A channel's done sets its flag and its
//   irq_clr bit clears it; set wins over clear. The registered OR of all flags
//   drives irq, so irq rises one edge after done.
// ---------------------------------------------------------------------------
module iob_pulse_train #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    iob_pulse_train_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HIGH,
        ST_LOW,
        ST_FINISH
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [WIDTH-1:0]    idx_q   [CHANNELS];
    logic [WIDTH-1:0]    idx_d   [CHANNELS];

    logic [WIDTH-1:0]    sh_start_q [CHANNELS];
    logic [WIDTH-1:0]    sh_dur_q   [CHANNELS];
    logic [WIDTH-1:0]    sh_per_q   [CHANNELS];
    logic [WIDTH-1:0]    sh_rep_q   [CHANNELS];

    logic [WIDTH-1:0]    low_len    [CHANNELS];
    logic [CHANNELS-1:0] last_pulse;
    logic [CHANNELS-1:0] begin_pulse;
    logic [CHANNELS-1:0] accept;

    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] busy_q,  busy_d;
    logic [CHANNELS-1:0] done_q,  done_d;

    // A trigger is accepted in any state unless stop is asserted in the same
    // cycle, because stop takes priority over trig.
    assign accept = bus.trig & ~bus.stop;

    // The shadow registers capture the configuration on the accepting edge
    // and hold it for the whole train. After that, the controller can rewrite
    // the cfg_* inputs without disturbing a running channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sh_start_q[c] <= ZERO;
                sh_dur_q[c]   <= ZERO;
                sh_per_q[c]   <= ZERO;
                sh_rep_q[c]   <= ZERO;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept[c]) begin
                    sh_start_q[c] <= bus.cfg_start[c*WIDTH +: WIDTH];
                    sh_dur_q[c]   <= bus.cfg_duration[c*WIDTH +: WIDTH];
                    sh_per_q[c]   <= bus.cfg_period[c*WIDTH +: WIDTH];
                    sh_rep_q[c]   <= bus.cfg_repeat[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // This block derives the length of the low phase and detects the last
    // pulse. The effective period is cfg_period when it exceeds the duration
    // and duration+1 otherwise, so the low phase is period-duration or
    // exactly 1 cycle. Computing the difference directly avoids the overflow
    // that duration+1 would hit at the top of the WIDTH range. idx counts
    // completed pulses, so the current pulse is the last one when idx equals
    // repeat-1. Continuous mode (repeat=0) never has a last pulse.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (sh_per_q[c] > sh_dur_q[c]) begin
                low_len[c] = sh_per_q[c] - sh_dur_q[c];
            end else begin
                low_len[c] = ONE;
            end
            last_pulse[c] = (sh_rep_q[c] != ZERO) && (idx_q[c] == (sh_rep_q[c] - ONE));
        end
    end

    // This block holds the state, the phase counter, the pulse index and the
    // registered outputs. Because the outputs are registered, a state change
    // and its visible effect happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= ZERO;
                idx_q[c]   <= ZERO;
            end
            pulse_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                idx_q[c]   <= idx_d[c];
            end
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // This block is the next-state and output logic for every channel.
    // The phase counter restarts in each phase, so no sum of fields is ever
    // formed. DELAY counts 0..start, so start=0 still spends one cycle there
    // and the first rise lands at trigger+1+start. HIGH and LOW count from 1.
    // Both DELAY and LOW end by raising begin_pulse, which is resolved after
    // the case statement. Resolving it there lets a zero-duration
    // configuration skip HIGH entirely: it keeps the timing, the repeat count
    // and done, but never drives the output high. On the last pulse, the
    // falling edge goes straight to FINISH. That way done and the drop of
    // busy coincide with the end of the final high phase. Stop and re-trigger
    // are applied last so they override whatever the phase logic decided.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c]     = state_q[c];
            cnt_d[c]       = cnt_q[c];
            idx_d[c]       = idx_q[c];
            begin_pulse[c] = 1'b0;
            pulse_d[c]     = 1'b0;
            busy_d[c]      = busy_q[c];
            done_d[c]      = 1'b0;

            case (state_q[c])
                ST_IDLE: begin
                    busy_d[c] = 1'b0;
                end
                ST_DELAY: begin
                    if (cnt_q[c] == sh_start_q[c]) begin
                        begin_pulse[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + ONE;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q[c] == sh_dur_q[c]) begin
                        if (last_pulse[c]) begin
                            state_d[c] = ST_FINISH;
                            busy_d[c]  = 1'b0;
                            done_d[c]  = 1'b1;
                        end else begin
                            state_d[c] = ST_LOW;
                            cnt_d[c]   = ONE;
                            idx_d[c]   = idx_q[c] + ONE;
                        end
                    end else begin
                        cnt_d[c]   = cnt_q[c] + ONE;
                        pulse_d[c] = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_q[c] == low_len[c]) begin
                        begin_pulse[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + ONE;
                    end
                end
                ST_FINISH: begin
                    state_d[c] = ST_IDLE;
                    busy_d[c]  = 1'b0;
                end
                default: begin
                    state_d[c] = ST_IDLE;
                    busy_d[c]  = 1'b0;
                end
            endcase

            if (begin_pulse[c]) begin
                if (sh_dur_q[c] == ZERO) begin
                    if (last_pulse[c]) begin
                        state_d[c] = ST_FINISH;
                        busy_d[c]  = 1'b0;
                        done_d[c]  = 1'b1;
                    end else begin
                        state_d[c] = ST_LOW;
                        cnt_d[c]   = ONE;
                        idx_d[c]   = idx_q[c] + ONE;
                    end
                end else begin
                    state_d[c] = ST_HIGH;
                    cnt_d[c]   = ONE;
                    pulse_d[c] = 1'b1;
                end
            end

            if (bus.stop[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = ZERO;
                idx_d[c]   = ZERO;
                pulse_d[c] = 1'b0;
                busy_d[c]  = 1'b0;
                done_d[c]  = 1'b0;
            end else if (bus.trig[c]) begin
                state_d[c] = ST_DELAY;
                cnt_d[c]   = ZERO;
                idx_d[c]   = ZERO;
                pulse_d[c] = 1'b0;
                busy_d[c]  = 1'b1;
                done_d[c]  = 1'b0;
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef IOB_PULSE_TRAIN_IRQ_EN
    logic [CHANNELS-1:0] flag_q;
    logic [CHANNELS-1:0] flag_d;
    logic                irq_q;

    // Each flag is set on the same edge that raises done, and set wins over
    // clear. irq registers the OR of the flags, so it follows one edge after
    // done and drops one edge after the last flag is cleared.
    always_comb begin
        flag_d = done_d | (flag_q & ~bus.irq_clr);
    end

    // This block holds the sticky flags and the registered interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            irq_q  <= |flag_q;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_iob_pulse_train.sv
// ---------------------------------------------------------------------------
// tb_iob_pulse_train
//
// Self-checking bench for iob_pulse_train. A timing model checks every
// channel's outputs after every edge. The model works directly from trigger
// edges and the closed-form pulse positions. Directed literal checks pin the
// expected edges of each scenario. Also covers IOB_PULSE_TRAIN_IRQ_EN when
// that macro is defined.
// ---------------------------------------------------------------------------
module tb_iob_pulse_train;

    localparam int CH = 2;
    localparam int W  = 16;

    logic clk;
    logic rst_n;

    iob_pulse_train_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    iob_pulse_train #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     tests    = 0;
    int     failures = 0;
    longint cyc      = 0;

    logic   m_active [CH];
    longint m_k [CH];
    longint m_s [CH];
    longint m_d [CH];
    longint m_p [CH];
    longint m_r [CH];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached at edge %0d, expected the bench to finish earlier", cyc);
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic setCfg(input int c, input int s, input int d, input int p, input int r);
        bus.cfg_start[c*W +: W]    = W'(s);
        bus.cfg_duration[c*W +: W] = W'(d);
        bus.cfg_period[c*W +: W]   = W'(p);
        bus.cfg_repeat[c*W +: W]   = W'(r);
    endtask

    // Drives trig/stop for exactly one sampling edge and returns that edge
    // number. It returns at the falling edge right after the sampling edge.
    task automatic applyStimulus(input logic [CH-1:0] t, input logic [CH-1:0] s, output longint k);
        @(negedge clk);
        bus.trig = t;
        bus.stop = s;
        k = cyc + 1;
        @(negedge clk);
        bus.trig = '0;
        bus.stop = '0;
    endtask

    // Moves to the falling edge that follows rising edge number t.
    task automatic atEdge(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    // Expected outputs after edge t for channel c. Pulse n rises at
    // k+1+S+n*P and lasts D edges. done falls on the end of the last pulse.
    function automatic void modelOut(input int c, input longint t,
                                     output logic p, output logic b, output logic d);
        longint eff;
        longint base;
        longint rel;
        longint last;
        p = 1'b0;
        b = 1'b0;
        d = 1'b0;
        if (!m_active[c]) return;
        eff  = (m_p[c] > m_d[c]) ? m_p[c] : m_d[c] + 1;
        base = m_k[c] + 1 + m_s[c];
        last = base + (m_r[c] - 1) * eff + m_d[c];
        d = (m_r[c] != 0) && (t == last);
        b = (m_r[c] == 0) || (t < last);
        rel = t - base;
        if (rel >= 0 && m_d[c] > 0 && (rel % eff) < m_d[c] && (m_r[c] == 0 || rel / eff < m_r[c]))
            p = 1'b1;
    endfunction

    // The model registers triggers on the rising edge and compares all
    // outputs on the following falling edge.
    initial begin
        logic ep;
        logic eb;
        logic ed;
        for (int c = 0; c < CH; c++) m_active[c] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < CH; c++) begin
                if (!rst_n || bus.stop[c]) begin
                    m_active[c] = 1'b0;
                end else if (bus.trig[c]) begin
                    m_active[c] = 1'b1;
                    m_k[c] = cyc;
                    m_s[c] = longint'(bus.cfg_start[c*W +: W]);
                    m_d[c] = longint'(bus.cfg_duration[c*W +: W]);
                    m_p[c] = longint'(bus.cfg_period[c*W +: W]);
                    m_r[c] = longint'(bus.cfg_repeat[c*W +: W]);
                end
            end
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (!rst_n) m_active[c] = 1'b0;
                modelOut(c, cyc, ep, eb, ed);
                checkOutput($sformatf("model pulse_out[%0d]", c), 32'(bus.pulse_out[c]), 32'(ep));
                checkOutput($sformatf("model busy[%0d]", c), 32'(bus.busy[c]), 32'(eb));
                checkOutput($sformatf("model done[%0d]", c), 32'(bus.done[c]), 32'(ed));
                if (ed) m_active[c] = 1'b0;
            end
        end
    end

    // Directed scenarios with hand-computed edges.
    initial begin
        longint k;
        longint k2;
        rst_n        = 1'b0;
        bus.trig     = '0;
        bus.stop     = '0;
        bus.cfg_start    = '0;
        bus.cfg_duration = '0;
        bus.cfg_period   = '0;
        bus.cfg_repeat   = '0;
`ifdef IOB_PULSE_TRAIN_IRQ_EN
        bus.irq_clr  = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset pulse_out", 32'(bus.pulse_out), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic train: start 3, duration 2, period 5, three pulses. The cfg
        // inputs are rewritten right after the trigger and must be ignored.
        setCfg(0, 3, 2, 5, 3);
        applyStimulus(2'b01, 2'b00, k);
        setCfg(0, 9, 9, 9, 9);
        atEdge(k + 3);  checkOutput("t1 pulse before rise", 32'(bus.pulse_out[0]), 32'd0);
        atEdge(k + 4);  checkOutput("t1 first rise", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 6);  checkOutput("t1 first fall", 32'(bus.pulse_out[0]), 32'd0);
        atEdge(k + 14); checkOutput("t1 third pulse", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 15); checkOutput("t1 busy before done", 32'(bus.busy[0]), 32'd1);
        atEdge(k + 16); checkOutput("t1 done", 32'(bus.done[0]), 32'd1);
                        checkOutput("t1 busy at done", 32'(bus.busy[0]), 32'd0);
        atEdge(k + 17); checkOutput("t1 done one cycle", 32'(bus.done[0]), 32'd0);
        atEdge(k + 19);

        // Period shorter than duration: effective period 5.
        setCfg(0, 0, 4, 3, 2);
        applyStimulus(2'b01, 2'b00, k);
        atEdge(k + 1);  checkOutput("t2 rise", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 4);  checkOutput("t2 still high", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 5);  checkOutput("t2 forced low gap", 32'(bus.pulse_out[0]), 32'd0);
        atEdge(k + 6);  checkOutput("t2 second rise", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 10); checkOutput("t2 done", 32'(bus.done[0]), 32'd1);
        atEdge(k + 12);

        // Continuous toggle, then stop.
        setCfg(0, 0, 1, 2, 0);
        applyStimulus(2'b01, 2'b00, k);
        atEdge(k + 1);  checkOutput("t3 toggle high", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 2);  checkOutput("t3 toggle low", 32'(bus.pulse_out[0]), 32'd0);
        atEdge(k + 3);  checkOutput("t3 toggle high again", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k + 8);
        applyStimulus(2'b00, 2'b01, k2);
        checkOutput("t3 stop pulse", 32'(bus.pulse_out[0]), 32'd0);
        checkOutput("t3 stop busy", 32'(bus.busy[0]), 32'd0);
        atEdge(k2 + 3);

        // Re-trigger at the middle of the second pulse.
        setCfg(0, 0, 3, 6, 2);
        applyStimulus(2'b01, 2'b00, k);
        setCfg(0, 0, 2, 4, 1);
        atEdge(k + 6);
        applyStimulus(2'b01, 2'b00, k2);
        checkOutput("t4 retrig edge is mid pulse", 32'(k2 - k), 32'd8);
        checkOutput("t4 pulse dropped", 32'(bus.pulse_out[0]), 32'd0);
        checkOutput("t4 still busy", 32'(bus.busy[0]), 32'd1);
        atEdge(k2 + 1); checkOutput("t4 restart rise", 32'(bus.pulse_out[0]), 32'd1);
        atEdge(k2 + 3); checkOutput("t4 single done", 32'(bus.done[0]), 32'd1);
        atEdge(k2 + 5);

        // Both channels together with different configs.
        setCfg(0, 1, 1, 3, 2);
        setCfg(1, 2, 3, 4, 1);
        applyStimulus(2'b11, 2'b00, k);
        atEdge(k + 2);  checkOutput("t5 pulses ch0 only", 32'(bus.pulse_out), 32'd1);
        atEdge(k + 3);  checkOutput("t5 pulses ch1 only", 32'(bus.pulse_out), 32'd2);
        atEdge(k + 5);  checkOutput("t5 pulses both", 32'(bus.pulse_out), 32'd3);
        atEdge(k + 6);  checkOutput("t5 done both", 32'(bus.done), 32'd3);
                        checkOutput("t5 busy none", 32'(bus.busy), 32'd0);
        atEdge(k + 8);
        applyStimulus(2'b10, 2'b10, k2);
        checkOutput("t5 trig+stop busy", 32'(bus.busy), 32'd0);
        atEdge(k2 + 2); checkOutput("t5 trig+stop idle", 32'(bus.busy), 32'd0);

        // Zero duration: timing and done still run.
        setCfg(1, 1, 0, 2, 2);
        applyStimulus(2'b10, 2'b00, k);
        atEdge(k + 3);  checkOutput("t6 busy", 32'(bus.busy[1]), 32'd1);
                        checkOutput("t6 never high", 32'(bus.pulse_out[1]), 32'd0);
        atEdge(k + 4);  checkOutput("t6 done", 32'(bus.done), 32'd2);
        atEdge(k + 6);

        // Asynchronous reset during a high phase.
        setCfg(0, 0, 5, 10, 1);
        applyStimulus(2'b01, 2'b00, k);
        atEdge(k + 2);  checkOutput("t7 high before reset", 32'(bus.pulse_out[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t7 async pulse", 32'(bus.pulse_out), 32'd0);
        checkOutput("t7 async busy", 32'(bus.busy), 32'd0);
        checkOutput("t7 async done", 32'(bus.done), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef IOB_PULSE_TRAIN_IRQ_EN
        // irq follows done by one edge and stays up until cleared.
        setCfg(0, 0, 1, 2, 1);
        applyStimulus(2'b01, 2'b00, k);
        atEdge(k + 2);  checkOutput("irq done", 32'(bus.done[0]), 32'd1);
                        checkOutput("irq not yet", 32'(bus.irq), 32'd0);
        atEdge(k + 3);  checkOutput("irq rises", 32'(bus.irq), 32'd1);
        bus.irq_clr = 2'b01;
        atEdge(k + 4);  checkOutput("irq second cycle", 32'(bus.irq), 32'd1);
        bus.irq_clr = 2'b00;
        atEdge(k + 5);  checkOutput("irq cleared", 32'(bus.irq), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
